// File: rtl/brnfck_pkg.sv
// brnfck controller shared types: datapath command codes, FSM states,
// command characters and the decoded symbol class bundle.
package brnfck_pkg;

  typedef enum logic [4:0] {
    CS_NOP        = 5'd0,
    CS_SYMBOL_RD  = 5'd1,
    CS_ZERO_STATE = 5'd2,
    CS_MHDPP      = 5'd3,
    CS_MHDMM      = 5'd4,
    CS_HDPP       = 5'd5,
    CS_HDMM       = 5'd6,
    CS_NEXT       = 5'd7,
    CS_RDBYTE     = 5'd8,
    CS_TORIGHT    = 5'd9,
    CS_TOLEFT     = 5'd10,
    CS_CPPR       = 5'd11,
    CS_CMMR       = 5'd12,
    CS_CPPL       = 5'd13,
    CS_CMML       = 5'd14,
    CS_PCMM       = 5'd15
  } ctrl_t;

  typedef enum logic [2:0] {
    LOAD   = 3'd0,
    CLEAR  = 3'd1,
    EXEC   = 3'd2,
    SCAN_R = 3'd3,
    SCAN_L = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam logic [7:0] SYM_INC   = 8'h2B;
  localparam logic [7:0] SYM_DEC   = 8'h2D;
  localparam logic [7:0] SYM_RIGHT = 8'h3E;
  localparam logic [7:0] SYM_LEFT  = 8'h3C;
  localparam logic [7:0] SYM_OUT   = 8'h2E;
  localparam logic [7:0] SYM_IN    = 8'h2C;
  localparam logic [7:0] SYM_OPEN  = 8'h5B;
  localparam logic [7:0] SYM_CLOSE = 8'h5D;

  typedef struct packed {
    logic inc;
    logic dec;
    logic right;
    logic left;
    logic out;
    logic in;
    logic open;
    logic close;
    logic term;
    logic other;
  } sym_t;

endpackage

// File: rtl/brnfck_if.sv
// Byte I/O handshake bundle between the environment (master)
// and the brnfck controller (slave).
interface brnfck_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_valid
  );
endinterface

// File: rtl/brnfck_symdec.sv
// Program symbol to one-hot class; the terminator wins over any
// command character it might collide with.
module brnfck_symdec
  import brnfck_pkg::*;
#(
  parameter logic [7:0] TERMINATOR = 8'h00
) (
  input  logic [7:0] symbol,
  output sym_t       cls
);
  logic term;

  assign term = (symbol == TERMINATOR);

  always_comb begin
    cls      = '0;
    cls.term = term;
    if (!term) begin
      unique case (symbol)
        SYM_INC:   cls.inc   = 1'b1;
        SYM_DEC:   cls.dec   = 1'b1;
        SYM_RIGHT: cls.right = 1'b1;
        SYM_LEFT:  cls.left  = 1'b1;
        SYM_OUT:   cls.out   = 1'b1;
        SYM_IN:    cls.in    = 1'b1;
        SYM_OPEN:  cls.open  = 1'b1;
        SYM_CLOSE: cls.close = 1'b1;
        default:   cls.other = 1'b1;
      endcase
    end
  end
endmodule

// File: rtl/brnfck_control.sv
// brnfck control FSM: load, tape clear, execution with bracket scans.
// Optional BRNFCK_STEP_EN adds a step input gating EXEC and the scans.
module brnfck_control
  import brnfck_pkg::*;
#(
  parameter logic [7:0] TERMINATOR     = 8'h00,
  parameter bit         CLEAR_ON_START = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
`ifdef BRNFCK_STEP_EN
  input  logic       step,
`endif
  input  logic [7:0] symbol,
  input  logic [2:0] data_signal,
  brnfck_if.slave    io,
  output ctrl_t      control_signal,
  output logic       halted,
  output logic       error
);
  state_t     state, nxt;
  ctrl_t      cs;
  sym_t       cls;
  logic [7:0] cnt;
  logic       cnt_inc, set_err, go;
  logic       in_ready, out_valid;

`ifdef BRNFCK_STEP_EN
  assign go = step;
`else
  assign go = 1'b1;
`endif

  brnfck_symdec #(.TERMINATOR(TERMINATOR)) u_symdec (
    .symbol (symbol),
    .cls    (cls)
  );

  always_comb begin
    cs        = CS_NOP;
    nxt       = state;
    cnt_inc   = 1'b0;
    set_err   = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (io.in_valid) begin
          cs = CS_SYMBOL_RD;
          if (io.in_data == TERMINATOR) begin
            nxt = CLEAR_ON_START ? CLEAR : EXEC;
          end else if (cnt == 8'hFF) begin
            set_err = 1'b1;
            nxt     = HALT;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      CLEAR: begin
        cs = CS_ZERO_STATE;
        if (data_signal[0]) nxt = EXEC;
      end
      EXEC: if (go) begin
        unique case (1'b1)
          cls.inc:   cs = CS_MHDPP;
          cls.dec:   cs = CS_MHDMM;
          cls.right: cs = CS_HDPP;
          cls.left:  cs = CS_HDMM;
          cls.out: begin
            out_valid = 1'b1;
            cs = io.out_ready ? CS_NEXT : CS_NOP;
          end
          cls.in: begin
            in_ready = 1'b1;
            cs = io.in_valid ? CS_RDBYTE : CS_NOP;
          end
          cls.open: begin
            cs = data_signal[1] ? CS_TORIGHT : CS_NEXT;
            if (data_signal[1]) nxt = SCAN_R;
          end
          cls.close: begin
            cs = data_signal[1] ? CS_NEXT : CS_TOLEFT;
            if (!data_signal[1]) nxt = SCAN_L;
          end
          cls.term: nxt = HALT;
          default:  cs = CS_NEXT;
        endcase
      end
      SCAN_R: if (go) begin
        unique case (1'b1)
          cls.open: cs = CS_CPPR;
          cls.close: begin
            cs = data_signal[2] ? CS_CMMR : CS_NEXT;
            if (!data_signal[2]) nxt = EXEC;
          end
          cls.term: begin
            set_err = 1'b1;
            nxt     = HALT;
          end
          default: cs = CS_NEXT;
        endcase
      end
      SCAN_L: if (go) begin
        unique case (1'b1)
          cls.close: cs = CS_CPPL;
          cls.open: begin
            cs = data_signal[2] ? CS_CMML : CS_NEXT;
            if (!data_signal[2]) nxt = EXEC;
          end
          cls.term: begin
            set_err = 1'b1;
            nxt     = HALT;
          end
          default: cs = CS_PCMM;
        endcase
      end
      HALT:    nxt = HALT;
      default: nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= LOAD;
      cnt    <= '0;
      halted <= 1'b0;
      error  <= 1'b0;
    end else begin
      state  <= nxt;
      halted <= (nxt == HALT);
      if (cnt_inc) cnt <= cnt + 8'd1;
      if (set_err) error <= 1'b1;
    end
  end

  assign control_signal = cs;
  assign io.in_ready    = in_ready;
  assign io.out_valid   = out_valid;
endmodule

// File: tb/tb_brnfck_control.sv
// Directed table-driven bench for brnfck_control: load, clear,
// execution, bracket scans, error paths and asynchronous reset.
module tb_brnfck_control;
  import brnfck_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] symbol = 8'h00;
  logic [2:0] ds = 3'b000;
  ctrl_t      cs;
  logic       halted, error;

  brnfck_if io();

  brnfck_control dut (
    .clk            (clk),
    .rst            (rst),
`ifdef BRNFCK_STEP_EN
    .step           (1'b1),
`endif
    .symbol         (symbol),
    .data_signal    (ds),
    .io             (io),
    .control_signal (cs),
    .halted         (halted),
    .error          (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] sym;
    logic [2:0] ds;
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    ctrl_t      cs;
    logic       ir;
    logic       ov;
    logic       hl;
    logic       er;
  } vec_t;

  vec_t tbl[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(string n, logic [7:0] s, logic [2:0] d,
                              logic iv, logic [7:0] id, logic ordy,
                              ctrl_t c, logic ir, logic ov,
                              logic hl, logic er);
    vec_t v;
    v.name = n; v.sym = s; v.ds = d; v.iv = iv; v.id = id;
    v.ordy = ordy; v.cs = c; v.ir = ir; v.ov = ov;
    v.hl = hl; v.er = er;
    tbl.push_back(v);
  endfunction

  task automatic drive(logic [7:0] s, logic [2:0] d, logic iv,
                       logic [7:0] id, logic ordy);
    @(negedge clk);
    symbol       = s;
    ds           = d;
    io.in_valid  = iv;
    io.in_data   = id;
    io.out_ready = ordy;
    #1;
  endtask

  task automatic run();
    foreach (tbl[i]) begin
      drive(tbl[i].sym, tbl[i].ds, tbl[i].iv, tbl[i].id, tbl[i].ordy);
      chk({tbl[i].name, "/cs"}, 32'(cs), 32'(tbl[i].cs));
      chk({tbl[i].name, "/in_ready"}, 32'(io.in_ready), 32'(tbl[i].ir));
      chk({tbl[i].name, "/out_valid"}, 32'(io.out_valid), 32'(tbl[i].ov));
      chk({tbl[i].name, "/halted"}, 32'(halted), 32'(tbl[i].hl));
      chk({tbl[i].name, "/error"}, 32'(error), 32'(tbl[i].er));
    end
    tbl.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst          = 1'b1;
    io.in_valid  = 1'b0;
    io.in_data   = 8'h00;
    io.out_ready = 1'b0;
    symbol       = 8'h00;
    ds           = 3'b000;
    #1;
    chk("reset/cs", 32'(cs), 32'(CS_NOP));
    chk("reset/in_ready", 32'(io.in_ready), 32'd1);
    chk("reset/out_valid", 32'(io.out_valid), 32'd0);
    chk("reset/halted", 32'(halted), 32'd0);
    chk("reset/error", 32'(error), 32'd0);
    #2 rst = 1'b0;
  endtask

  // Returns the count of ZERO_STATE cycles seen during the clear phase.
  task automatic clear_phase(output int zc);
    zc = 0;
    for (int i = 0; i < 256; i++) begin
      drive(8'h41, (i == 255) ? 3'b001 : 3'b000, 1'b0, 8'h00, 1'b0);
      if (cs == CS_ZERO_STATE) zc++;
    end
  endtask

  task automatic to_exec();
    int zc;
    do_reset();
    drive(8'h00, 3'b000, 1'b1, 8'h00, 1'b0);
    clear_phase(zc);
  endtask

  initial begin
    int zc;
    io.in_valid  = 1'b0;
    io.in_data   = 8'h00;
    io.out_ready = 1'b0;

    // Load "+." then terminator, clear, run to halt
    do_reset();
    add("ld_idle", 8'h00, 3'b000, 0, 8'h00, 0, CS_NOP,       1, 0, 0, 0);
    add("ld_plus", 8'h00, 3'b000, 1, "+",   0, CS_SYMBOL_RD, 1, 0, 0, 0);
    add("ld_dot",  8'h00, 3'b000, 1, ".",   0, CS_SYMBOL_RD, 1, 0, 0, 0);
    add("ld_term", 8'h00, 3'b000, 1, 8'h00, 0, CS_SYMBOL_RD, 1, 0, 0, 0);
    run();
    clear_phase(zc);
    chk("clear_len", 32'(zc), 32'd256);
    add("ex_plus", "+",   3'b000, 0, 8'h00, 1, CS_MHDPP, 0, 0, 0, 0);
    add("ex_dot",  ".",   3'b000, 0, 8'h00, 1, CS_NEXT,  0, 1, 0, 0);
    add("ex_term", 8'h00, 3'b000, 0, 8'h00, 1, CS_NOP,   0, 0, 0, 0);
    add("halt0",   "A",   3'b000, 1, 8'h41, 1, CS_NOP,   0, 0, 1, 0);
    add("halt1",   "[",   3'b010, 0, 8'h00, 1, CS_NOP,   0, 0, 1, 0);
    run();

    // Output stall, input wait, simple commands, comment byte
    to_exec();
    for (int i = 0; i < 5; i++)
      add("out_stall", ".", 3'b000, 0, 8'h00, 0, CS_NOP, 0, 1, 0, 0);
    add("out_go",  ".", 3'b000, 0, 8'h00, 1, CS_NEXT,   0, 1, 0, 0);
    add("in_wait", ",", 3'b000, 0, 8'h00, 0, CS_NOP,    1, 0, 0, 0);
    add("in_go",   ",", 3'b000, 1, 8'h55, 0, CS_RDBYTE, 1, 0, 0, 0);
    add("right",   ">", 3'b000, 0, 8'h00, 0, CS_HDPP,   0, 0, 0, 0);
    add("left",    "<", 3'b000, 0, 8'h00, 0, CS_HDMM,   0, 0, 0, 0);
    add("minus",   "-", 3'b000, 0, 8'h00, 0, CS_MHDMM,  0, 0, 0, 0);
    add("comment", "x", 3'b000, 0, 8'h00, 0, CS_NEXT,   0, 0, 0, 0);
    run();

    // "[+[-]]." with cell zero: forward scan with nesting
    to_exec();
    add("open_z",  "[",   3'b010, 0, 8'h00, 0, CS_TORIGHT, 0, 0, 0, 0);
    add("sr_plus", "+",   3'b010, 0, 8'h00, 0, CS_NEXT,    0, 0, 0, 0);
    add("sr_open", "[",   3'b010, 0, 8'h00, 0, CS_CPPR,    0, 0, 0, 0);
    add("sr_min",  "-",   3'b110, 0, 8'h00, 0, CS_NEXT,    0, 0, 0, 0);
    add("sr_cmm",  "]",   3'b110, 0, 8'h00, 0, CS_CMMR,    0, 0, 0, 0);
    add("sr_done", "]",   3'b010, 0, 8'h00, 0, CS_NEXT,    0, 0, 0, 0);
    add("sr_dot",  ".",   3'b010, 0, 8'h00, 1, CS_NEXT,    0, 1, 0, 0);
    add("sr_term", 8'h00, 3'b010, 0, 8'h00, 0, CS_NOP,     0, 0, 0, 0);
    add("sr_halt", "A",   3'b000, 0, 8'h00, 0, CS_NOP,     0, 0, 1, 0);
    run();

    // "+[]" with cell nonzero: backward scan, resume at ']'
    to_exec();
    add("bl_plus",  "+", 3'b000, 0, 8'h00, 0, CS_MHDPP,  0, 0, 0, 0);
    add("bl_open",  "[", 3'b000, 0, 8'h00, 0, CS_NEXT,   0, 0, 0, 0);
    add("bl_close", "]", 3'b000, 0, 8'h00, 0, CS_TOLEFT, 0, 0, 0, 0);
    add("sl_cppl",  "]", 3'b100, 0, 8'h00, 0, CS_CPPL,   0, 0, 0, 0);
    add("sl_other", "A", 3'b100, 0, 8'h00, 0, CS_PCMM,   0, 0, 0, 0);
    add("sl_cmml",  "[", 3'b100, 0, 8'h00, 0, CS_CMML,   0, 0, 0, 0);
    add("sl_done",  "[", 3'b000, 0, 8'h00, 0, CS_NEXT,   0, 0, 0, 0);
    add("resume",   "]", 3'b010, 0, 8'h00, 0, CS_NEXT,   0, 0, 0, 0);
    run();

    // "]" unmatched: backward scan hits terminator
    to_exec();
    add("um_close", "]",   3'b000, 0, 8'h00, 0, CS_TOLEFT, 0, 0, 0, 0);
    add("um_pcmm",  "A",   3'b000, 0, 8'h00, 0, CS_PCMM,   0, 0, 0, 0);
    add("um_term",  8'h00, 3'b000, 0, 8'h00, 0, CS_NOP,    0, 0, 0, 0);
    add("um_halt",  "+",   3'b000, 0, 8'h00, 0, CS_NOP,    0, 0, 1, 1);
    run();

    // Unmatched '[': forward scan hits terminator
    to_exec();
    add("ur_open", "[",   3'b010, 0, 8'h00, 0, CS_TORIGHT, 0, 0, 0, 0);
    add("ur_oth",  "A",   3'b010, 0, 8'h00, 0, CS_NEXT,    0, 0, 0, 0);
    add("ur_term", 8'h00, 3'b010, 0, 8'h00, 0, CS_NOP,     0, 0, 0, 0);
    add("ur_halt", "+",   3'b010, 0, 8'h00, 0, CS_NOP,     0, 0, 1, 1);
    run();

    // Reset during SCAN_R
    to_exec();
    add("rs_open", "[", 3'b010, 0, 8'h00, 0, CS_TORIGHT, 0, 0, 0, 0);
    add("rs_cppr", "[", 3'b010, 0, 8'h00, 0, CS_CPPR,    0, 0, 0, 0);
    run();
    do_reset();
    add("rs_load", "[", 3'b010, 0, 8'h00, 0, CS_NOP, 1, 0, 0, 0);
    run();

    // 255 bytes plus terminator fits
    do_reset();
    for (int i = 0; i < 255; i++) drive(8'h00, 3'b000, 1'b1, 8'h41, 1'b0);
    add("fit_term",  8'h00, 3'b000, 1, 8'h00, 0, CS_SYMBOL_RD,  1, 0, 0, 0);
    add("fit_clear", 8'h00, 3'b000, 0, 8'h00, 0, CS_ZERO_STATE, 0, 0, 0, 0);
    run();

    // 256th byte not the terminator is an error
    do_reset();
    for (int i = 0; i < 255; i++) drive(8'h00, 3'b000, 1'b1, 8'h41, 1'b0);
    add("ovf_byte", 8'h00, 3'b000, 1, 8'h41, 0, CS_SYMBOL_RD, 1, 0, 0, 0);
    add("ovf_halt", 8'h00, 3'b000, 1, 8'h00, 0, CS_NOP,       0, 0, 1, 1);
    run();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
